// File: rtl/mem_writeback.sv
// rtl/mem_writeback.sv - MEM stage with data-memory handshake and MEM/WB pipeline register
module mem_writeback #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ex_valid,
  input  logic             ex_RegWrite,
  input  logic             ex_MemtoReg,
  input  logic             ex_MemRead,
  input  logic             ex_MemWrite,
  input  logic             ex_overflow,
  input  logic [31:0]      ex_ALUResult,
  input  logic [31:0]      ex_StoreData,
  input  logic [4:0]       ex_WriteReg,
  output logic [31:0]      EXMEMALUResult,
  output logic [31:0]      MemtoMux,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_ready,
  output logic             mem_stall,
  output logic [4:0]       WriteReg,
  output logic [31:0]      DataMEMtoReg,
  output logic             WriteRegEnable,
  output logic             MEMWBoverflow,
  output logic             mem_fault,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [4:0]         wb_reg_q, wb_reg_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               wb_en_q, wb_en_d;
  logic               wb_ovf_q, wb_ovf_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic is_mem;
  logic misaligned;
  logic req;
  logic stall;
  logic complete;

  // Access sequencing, stall generation and MEM/WB next-state selection
  always_comb begin
    is_mem     = ex_MemRead | ex_MemWrite;
    misaligned = (ex_ALUResult[1:0] != 2'b00);
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    wb_en_d    = 1'b0;
    wb_ovf_d   = wb_ovf_q;
    fault_d    = 1'b0;
    retired_d  = retired_q;
    req        = 1'b0;
    stall      = 1'b0;
    complete   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            complete = 1'b1;
          end else if (misaligned) begin
            fault_d = 1'b1;
          end else begin
            req = 1'b1;
            if (dmem_ready) begin
              complete = 1'b1;
            end else begin
              stall      = 1'b1;
              state_d    = S_WAIT;
              wait_cnt_d = WAIT_W'(1);
            end
          end
        end
      end
      S_WAIT: begin
        // EX/MEM is frozen by the stall, so the request fields stay stable
        req = 1'b1;
        if (dmem_ready) begin
          complete   = 1'b1;
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
          fault_d    = 1'b1;
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else begin
          stall      = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
    endcase

    if (complete) begin
      wb_reg_d  = ex_WriteReg;
      wb_data_d = (ex_MemtoReg && is_mem) ? dmem_rdata : ex_ALUResult;
      wb_en_d   = ex_RegWrite && (ex_WriteReg != 5'd0);
      wb_ovf_d  = ex_overflow;
      retired_d = retired_q + CNT_W'(1);
    end

    if (Rst) begin
      req   = 1'b0;
      stall = 1'b0;
    end
  end

  // FSM state, wait counter and MEM/WB register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      wb_en_q    <= 1'b0;
      wb_ovf_q   <= 1'b0;
      fault_q    <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      wb_en_q    <= wb_en_d;
      wb_ovf_q   <= wb_ovf_d;
      fault_q    <= fault_d;
      retired_q  <= retired_d;
    end
  end

  assign EXMEMALUResult = ex_ALUResult;
  assign MemtoMux       = (complete && ex_MemRead) ? dmem_rdata : ex_ALUResult;
  assign dmem_req       = req;
  assign dmem_we        = req & ex_MemWrite;
  assign dmem_addr      = ex_ALUResult;
  assign dmem_wdata     = ex_StoreData;
  assign mem_stall      = stall;
  assign WriteReg       = wb_reg_q;
  assign DataMEMtoReg   = wb_data_q;
  assign WriteRegEnable = wb_en_q;
  assign MEMWBoverflow  = wb_ovf_q;
  assign mem_fault      = fault_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_mem_writeback.sv
// tb/tb_mem_writeback.sv - directed scoreboard bench for mem_writeback
module tb_mem_writeback;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_overflow;
  logic [31:0] ex_ALUResult, ex_StoreData;
  logic [4:0]  ex_WriteReg;
  logic [31:0] EXMEMALUResult, MemtoMux;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready, mem_stall;
  logic [4:0]  WriteReg;
  logic [31:0] DataMEMtoReg;
  logic        WriteRegEnable, MEMWBoverflow, mem_fault;
  logic [31:0] retired;

  typedef struct packed {
    logic [4:0]  wr;
    logic [31:0] data;
    logic        we;
    logic        ovf;
  } wb_t;

  wb_t         sb[$];
  wb_t         e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_retired = 0;

  mem_writeback #(.MAX_WAIT(15), .CNT_W(32)) dut (
    .Clk(Clk), .Rst(Rst),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_overflow(ex_overflow),
    .ex_ALUResult(ex_ALUResult), .ex_StoreData(ex_StoreData), .ex_WriteReg(ex_WriteReg),
    .EXMEMALUResult(EXMEMALUResult), .MemtoMux(MemtoMux),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .mem_stall(mem_stall),
    .WriteReg(WriteReg), .DataMEMtoReg(DataMEMtoReg), .WriteRegEnable(WriteRegEnable),
    .MEMWBoverflow(MEMWBoverflow), .mem_fault(mem_fault), .retired(retired)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_RegWrite = 0; ex_MemtoReg = 0; ex_MemRead = 0; ex_MemWrite = 0;
    ex_overflow = 0; ex_ALUResult = 0; ex_StoreData = 0; ex_WriteReg = 0;
    dmem_ready = 0; dmem_rdata = 0;
  endtask

  task automatic push(input logic [4:0] wr, input logic [31:0] data, input logic we, input logic ovf);
    wb_t x;
    x.wr = wr; x.data = data; x.we = we; x.ovf = ovf;
    sb.push_back(x);
    exp_retired++;
  endtask

  task automatic check_wb(input string tag);
    n_checks++;
    assert (sb.size() > 0) else begin
      n_errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_wr"}, WriteReg, e.wr);
      chk({tag, "_data"}, DataMEMtoReg, e.data);
      chk({tag, "_we"}, WriteRegEnable, e.we);
      chk({tag, "_ovf"}, MEMWBoverflow, e.ovf);
    end
    chk({tag, "_fault"}, mem_fault, 0);
    chk({tag, "_ret"}, retired, exp_retired);
  endtask

  task automatic check_bubble(input string tag, input logic fault);
    chk({tag, "_we"}, WriteRegEnable, 0);
    chk({tag, "_fault"}, mem_fault, fault);
    chk({tag, "_ret"}, retired, exp_retired);
  endtask

  initial begin
    Rst = 1; clear_ex();
    @(negedge Clk);
    ex_valid = 1; ex_MemRead = 1; ex_ALUResult = 32'h40;
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", mem_stall, 0);
    @(posedge Clk); #1;
    @(negedge Clk); Rst = 0; clear_ex(); #1;
    chk("rst_wr", WriteReg, 0);
    chk("rst_data", DataMEMtoReg, 0);
    chk("rst_we", WriteRegEnable, 0);
    chk("rst_ovf", MEMWBoverflow, 0);
    chk("rst_fault", mem_fault, 0);
    chk("rst_ret", retired, 0);

    // ALU op
    @(negedge Clk);
    ex_valid = 1; ex_RegWrite = 1; ex_ALUResult = 32'h1234; ex_WriteReg = 9; #1;
    chk("alu_fwd", EXMEMALUResult, 32'h1234);
    chk("alu_mux", MemtoMux, 32'h1234);
    chk("alu_req", dmem_req, 0);
    chk("alu_stall", mem_stall, 0);
    push(9, 32'h1234, 1, 0);
    @(posedge Clk); #1; check_wb("alu");

    // bubble holds fields
    @(negedge Clk); clear_ex();
    @(posedge Clk); #1;
    check_bubble("idle", 0);
    chk("idle_wr_hold", WriteReg, 9);

    // ALU op with overflow
    @(negedge Clk);
    ex_valid = 1; ex_RegWrite = 1; ex_overflow = 1; ex_ALUResult = 32'h7FFF_FFF0; ex_WriteReg = 3;
    push(3, 32'h7FFF_FFF0, 1, 1);
    @(posedge Clk); #1; check_wb("ovf");

    // zero-wait load
    @(negedge Clk); clear_ex();
    ex_valid = 1; ex_RegWrite = 1; ex_MemtoReg = 1; ex_MemRead = 1;
    ex_ALUResult = 32'h40; ex_WriteReg = 8; dmem_ready = 1; dmem_rdata = 32'hDEAD_BEEF; #1;
    chk("ld0_req", dmem_req, 1);
    chk("ld0_we", dmem_we, 0);
    chk("ld0_addr", dmem_addr, 32'h40);
    chk("ld0_stall", mem_stall, 0);
    chk("ld0_mux", MemtoMux, 32'hDEAD_BEEF);
    push(8, 32'hDEAD_BEEF, 1, 0);
    @(posedge Clk); #1; check_wb("ld0");

    // slow store, ready on 4th request cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk); clear_ex();
      ex_valid = 1; ex_MemWrite = 1; ex_ALUResult = 32'h80; ex_StoreData = 32'h55;
      ex_WriteReg = 5; dmem_ready = (i == 3); #1;
      chk("st_req", dmem_req, 1);
      chk("st_we", dmem_we, 1);
      chk("st_addr", dmem_addr, 32'h80);
      chk("st_wdata", dmem_wdata, 32'h55);
      chk("st_stall", mem_stall, (i < 3));
      if (i == 3) push(5, 32'h80, 0, 0);
      @(posedge Clk); #1;
      if (i < 3) check_bubble("st_wait", 0);
      else check_wb("st");
    end

    // load timeout
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk); clear_ex();
      ex_valid = 1; ex_RegWrite = 1; ex_MemtoReg = 1; ex_MemRead = 1;
      ex_ALUResult = 32'h100; ex_WriteReg = 7; #1;
      chk("to_req", dmem_req, 1);
      chk("to_stall", mem_stall, (i < 15));
      @(posedge Clk); #1;
      check_bubble("to", (i == 15));
    end
    @(negedge Clk); clear_ex();
    @(posedge Clk); #1;
    check_bubble("to_after", 0);

    // misaligned load
    @(negedge Clk);
    ex_valid = 1; ex_RegWrite = 1; ex_MemtoReg = 1; ex_MemRead = 1;
    ex_ALUResult = 32'h42; ex_WriteReg = 4; dmem_ready = 1; #1;
    chk("mis_req", dmem_req, 0);
    chk("mis_stall", mem_stall, 0);
    @(posedge Clk); #1;
    check_bubble("mis", 1);

    // write to $zero
    @(negedge Clk); clear_ex();
    ex_valid = 1; ex_RegWrite = 1; ex_ALUResult = 32'h77; ex_WriteReg = 0;
    push(0, 32'h77, 0, 0);
    @(posedge Clk); #1; check_wb("zero");

    // reset in the middle of a wait
    @(negedge Clk); clear_ex();
    ex_valid = 1; ex_RegWrite = 1; ex_MemtoReg = 1; ex_MemRead = 1;
    ex_ALUResult = 32'h200; ex_WriteReg = 10;
    @(posedge Clk); #1;
    @(negedge Clk); #1;
    chk("rw_stall", mem_stall, 1);
    @(posedge Clk); #1;
    @(negedge Clk); Rst = 1; #1;
    chk("rw_req", dmem_req, 0);
    chk("rw_stall_rst", mem_stall, 0);
    @(posedge Clk); #1;
    exp_retired = 0;
    chk("rw_wr", WriteReg, 0);
    chk("rw_data", DataMEMtoReg, 0);
    chk("rw_we", WriteRegEnable, 0);
    chk("rw_ovf", MEMWBoverflow, 0);
    chk("rw_fault", mem_fault, 0);
    chk("rw_ret", retired, 0);

    // FSM must be idle: misaligned access is rejected without a request
    @(negedge Clk); Rst = 0; clear_ex();
    ex_valid = 1; ex_MemRead = 1; ex_ALUResult = 32'h202; #1;
    chk("rw_mis_req", dmem_req, 0);
    @(posedge Clk); #1;
    check_bubble("rw_mis", 1);

    // subsequent load completes
    @(negedge Clk); clear_ex();
    ex_valid = 1; ex_RegWrite = 1; ex_MemtoReg = 1; ex_MemRead = 1;
    ex_ALUResult = 32'h200; ex_WriteReg = 10; dmem_ready = 1; dmem_rdata = 32'hCAFE_0001; #1;
    chk("rw_ld_stall", mem_stall, 0);
    chk("rw_ld_mux", MemtoMux, 32'hCAFE_0001);
    push(10, 32'hCAFE_0001, 1, 0);
    @(posedge Clk); #1; check_wb("rw_ld");

    @(negedge Clk); clear_ex();
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
